// File: rtl/multicycle_sequencer.sv
// Multi-cycle RV32 sequencer: steps FETCH/DECODE/EXEC/MEM/WB, runs the memory
// handshakes, gates IR/PC/RF writes, and provides halt, timeout fault and a retire counter.
//
// state  | meaning
// FETCH  | imem_req high, load IR on imem_ready
// DECODE | check opcode legality
// EXEC   | choose MEM or WB from mem_read/mem_write
// MEM    | dmem_req high until dmem_ready
// WB     | pc_we, rf_we, retire; park if halt_req
// HALT   | parked until halt_req drops
// FAULT  | illegal opcode or memory timeout; only rst exits
module multicycle_sequencer #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [6:0]  opcode,
  input  logic        reg_write,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        halt_req,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  output logic        imem_req,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        ir_we,
  output logic        pc_we,
  output logic        rf_we,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state,
  output logic [31:0] retired
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_t;

  // A zero TIMEOUT still needs a 1-bit counter to keep the declarations legal.
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] WAIT_LIMIT = CW'(TIMEOUT - 1);

  state_t        state_q, state_d;
  logic [CW-1:0] wait_cnt_q, wait_cnt_d;
  logic [31:0]   retired_q, retired_d;
  logic          mem_wait;
  logic          timed_out;

  function automatic logic is_legal(input logic [6:0] op);
    case (op)
      7'b0110011, 7'b0000011, 7'b0010011, 7'b0100011,
      7'b1100011, 7'b1101111, 7'b0110111, 7'b0010111: is_legal = 1'b1;
      default:                                        is_legal = 1'b0;
    endcase
  endfunction

  always_comb begin
    state_d    = state_q;
    wait_cnt_d = '0;
    retired_d  = retired_q;
    mem_wait   = ((state_q == S_FETCH) && !imem_ready) ||
                 ((state_q == S_MEM) && !dmem_ready);
    timed_out  = (TIMEOUT != 0) && mem_wait && (wait_cnt_q == WAIT_LIMIT);

    if (mem_wait && !timed_out) begin
      wait_cnt_d = wait_cnt_q + CW'(1);
    end

    case (state_q)
      S_FETCH: begin
        if (imem_ready)     state_d = S_DECODE;
        else if (timed_out) state_d = S_FAULT;
      end
      S_DECODE: state_d = is_legal(opcode) ? S_EXEC : S_FAULT;
      S_EXEC:   state_d = (mem_read || mem_write) ? S_MEM : S_WB;
      S_MEM: begin
        if (dmem_ready)     state_d = S_WB;
        else if (timed_out) state_d = S_FAULT;
      end
      S_WB: begin
        retired_d = retired_q + 32'd1;
        state_d   = halt_req ? S_HALT : S_FETCH;
      end
      S_HALT: begin
        if (!halt_req) state_d = S_FETCH;
      end
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_FETCH;
      wait_cnt_q <= '0;
      retired_q  <= '0;
    end else begin
      state_q    <= state_d;
      wait_cnt_q <= wait_cnt_d;
      retired_q  <= retired_d;
    end
  end

  // Reset parks the state in FETCH, so only the fetch strobes need explicit gating.
  assign imem_req = (state_q == S_FETCH) && !rst;
  assign ir_we    = imem_req && imem_ready;
  assign dmem_req = (state_q == S_MEM);
  assign dmem_we  = dmem_req && mem_write;
  assign pc_we    = (state_q == S_WB);
  assign rf_we    = pc_we && reg_write;
  assign halted   = (state_q == S_HALT);
  assign fault    = (state_q == S_FAULT);
  assign state    = state_q;
  assign retired  = retired_q;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed table-driven bench for multicycle_sequencer (TIMEOUT=3), plus
// hand-written sequences for fault stickiness, mid-instruction reset and counter wrap.
module tb_multicycle_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  opcode;
  logic        reg_write, mem_read, mem_write, halt_req, imem_ready, dmem_ready;
  logic        imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we, halted, fault;
  logic [2:0]  state;
  logic [31:0] retired;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [6:0] OP_ALU  = 7'b0110011;
  localparam logic [6:0] OP_LD   = 7'b0000011;
  localparam logic [6:0] OP_ST   = 7'b0100011;
  localparam logic [6:0] OP_BR   = 7'b1100011;
  localparam logic [6:0] OP_LUI  = 7'b0110111;
  localparam logic [6:0] OP_ADDI = 7'b0010011;

  // strobe bits: {imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we}
  localparam logic [5:0] SB_NONE  = 6'b000000;
  localparam logic [5:0] SB_FWAIT = 6'b100000;
  localparam logic [5:0] SB_FGO   = 6'b100100;
  localparam logic [5:0] SB_LD    = 6'b010000;
  localparam logic [5:0] SB_ST    = 6'b011000;
  localparam logic [5:0] SB_WB    = 6'b000010;
  localparam logic [5:0] SB_WBRF  = 6'b000011;

  typedef struct {
    logic [6:0]  op;
    logic        rw, mr, mw, hr, ir, dr;
    logic [2:0]  st;
    logic [5:0]  strb;
    logic        hal, flt;
    logic [31:0] ret;
  } vec_t;

  vec_t vq[$];

  multicycle_sequencer #(.TIMEOUT(3)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .reg_write(reg_write),
    .mem_read(mem_read), .mem_write(mem_write), .halt_req(halt_req),
    .imem_ready(imem_ready), .dmem_ready(dmem_ready), .imem_req(imem_req),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .ir_we(ir_we), .pc_we(pc_we),
    .rf_we(rf_we), .halted(halted), .fault(fault), .state(state), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic [6:0] op, input logic rw, input logic mr, input logic mw,
                     input logic hr, input logic ir, input logic dr, input logic [2:0] st,
                     input logic [5:0] strb, input logic hal, input logic flt,
                     input logic [31:0] ret);
    vec_t v;
    v.op = op; v.rw = rw; v.mr = mr; v.mw = mw; v.hr = hr; v.ir = ir; v.dr = dr;
    v.st = st; v.strb = strb; v.hal = hal; v.flt = flt; v.ret = ret;
    vq.push_back(v);
  endtask

  function automatic logic [5:0] strobes();
    return {imem_req, dmem_req, dmem_we, ir_we, pc_we, rf_we};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //    op       rw mr mw hr ir dr st  strobes   hal flt ret
    add(OP_ALU,  1, 0, 0, 0, 1, 0, 0, SB_FGO,   0, 0, 0);
    add(OP_ALU,  1, 0, 0, 0, 1, 0, 1, SB_NONE,  0, 0, 0);
    add(OP_ALU,  1, 0, 0, 0, 1, 0, 2, SB_NONE,  0, 0, 0);
    add(OP_ALU,  1, 0, 0, 0, 1, 0, 4, SB_WBRF,  0, 0, 0);
    add(OP_LD,   1, 1, 0, 0, 1, 0, 0, SB_FGO,   0, 0, 1);
    add(OP_LD,   1, 1, 0, 0, 1, 0, 1, SB_NONE,  0, 0, 1);
    add(OP_LD,   1, 1, 0, 0, 1, 0, 2, SB_NONE,  0, 0, 1);
    add(OP_LD,   1, 1, 0, 0, 1, 0, 3, SB_LD,    0, 0, 1);
    add(OP_LD,   1, 1, 0, 0, 1, 0, 3, SB_LD,    0, 0, 1);
    add(OP_LD,   1, 1, 0, 0, 1, 1, 3, SB_LD,    0, 0, 1);
    add(OP_LD,   1, 1, 0, 0, 1, 1, 4, SB_WBRF,  0, 0, 1);
    add(OP_ST,   0, 1, 1, 0, 1, 1, 0, SB_FGO,   0, 0, 2);
    add(OP_ST,   0, 1, 1, 0, 1, 1, 1, SB_NONE,  0, 0, 2);
    add(OP_ST,   0, 1, 1, 0, 1, 1, 2, SB_NONE,  0, 0, 2);
    add(OP_ST,   0, 1, 1, 0, 1, 1, 3, SB_ST,    0, 0, 2);
    add(OP_ST,   0, 1, 1, 0, 1, 1, 4, SB_WB,    0, 0, 2);
    add(OP_BR,   0, 0, 0, 0, 1, 1, 0, SB_FGO,   0, 0, 3);
    add(OP_BR,   0, 0, 0, 0, 1, 1, 1, SB_NONE,  0, 0, 3);
    add(OP_BR,   0, 0, 0, 0, 1, 1, 2, SB_NONE,  0, 0, 3);
    add(OP_BR,   0, 0, 0, 0, 1, 1, 4, SB_WB,    0, 0, 3);
    add(OP_LUI,  1, 0, 0, 0, 0, 1, 0, SB_FWAIT, 0, 0, 4);
    add(OP_LUI,  1, 0, 0, 0, 0, 1, 0, SB_FWAIT, 0, 0, 4);
    add(OP_LUI,  1, 0, 0, 0, 1, 1, 0, SB_FGO,   0, 0, 4);
    add(OP_LUI,  1, 0, 0, 0, 1, 1, 1, SB_NONE,  0, 0, 4);
    add(OP_LUI,  1, 0, 0, 0, 1, 1, 2, SB_NONE,  0, 0, 4);
    add(OP_LUI,  1, 0, 0, 0, 1, 1, 4, SB_WBRF,  0, 0, 4);
    add(OP_ADDI, 1, 0, 0, 1, 1, 1, 0, SB_FGO,   0, 0, 5);
    add(OP_ADDI, 1, 0, 0, 0, 1, 1, 1, SB_NONE,  0, 0, 5);
    add(OP_ADDI, 1, 0, 0, 1, 1, 1, 2, SB_NONE,  0, 0, 5);
    add(OP_ADDI, 1, 0, 0, 1, 1, 1, 4, SB_WBRF,  0, 0, 5);
    add(OP_ADDI, 1, 0, 0, 1, 1, 1, 5, SB_NONE,  1, 0, 6);
    add(OP_ADDI, 1, 0, 0, 1, 1, 1, 5, SB_NONE,  1, 0, 6);
    add(OP_ADDI, 1, 0, 0, 0, 0, 1, 5, SB_NONE,  1, 0, 6);
    add(OP_ADDI, 1, 0, 0, 0, 0, 1, 0, SB_FWAIT, 0, 0, 6);
    add(OP_ADDI, 1, 0, 0, 0, 0, 1, 0, SB_FWAIT, 0, 0, 6);
    add(OP_ADDI, 1, 0, 0, 0, 0, 1, 0, SB_FWAIT, 0, 0, 6);
    add(OP_ADDI, 1, 0, 0, 0, 0, 1, 6, SB_NONE,  0, 1, 6);

    rst = 1'b1; opcode = OP_ALU; reg_write = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    halt_req = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;

    @(negedge clk);
    imem_ready = 1'b1;
    #1;
    chk("reset state",   32'(state),     32'd0);
    chk("reset strobes", 32'(strobes()), 32'd0);
    chk("reset retired", retired,        32'd0);
    chk("reset flags",   32'({halted, fault}), 32'd0);
    imem_ready = 1'b0;
    rst = 1'b0;

    foreach (vq[i]) begin
      @(negedge clk);
      opcode = vq[i].op; reg_write = vq[i].rw; mem_read = vq[i].mr; mem_write = vq[i].mw;
      halt_req = vq[i].hr; imem_ready = vq[i].ir; dmem_ready = vq[i].dr;
      #1;
      chk($sformatf("row%0d state", i),   32'(state),     32'(vq[i].st));
      chk($sformatf("row%0d strobes", i), 32'(strobes()), 32'(vq[i].strb));
      chk($sformatf("row%0d halted", i),  32'(halted),    32'(vq[i].hal));
      chk($sformatf("row%0d fault", i),   32'(fault),     32'(vq[i].flt));
      chk($sformatf("row%0d retired", i), retired,        vq[i].ret);
    end

    // Reset out of FAULT, retire one ALU op, then reset in the middle of a load.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst from fault state", 32'(state), 32'd0);
    chk("rst from fault flag",  32'(fault), 32'd0);
    chk("rst clears retired",   retired,    32'd0);
    @(negedge clk);
    rst = 1'b0; opcode = OP_ALU; reg_write = 1'b1; mem_read = 1'b0; mem_write = 1'b0;
    imem_ready = 1'b1; dmem_ready = 1'b0; halt_req = 1'b0;
    repeat (4) @(negedge clk);
    #1;
    chk("alu retire count", retired,    32'd1);
    chk("alu back to fetch", 32'(state), 32'd0);
    opcode = OP_LD; mem_read = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk("load in mem state", 32'(state),     32'd3);
    chk("load mem strobes",  32'(strobes()), 32'(SB_LD));
    rst = 1'b1;
    #1;
    chk("mid-mem rst strobes", 32'(strobes()), 32'd0);
    chk("mid-mem rst state",   32'(state),     32'd0);
    chk("mid-mem rst retired", retired,        32'd0);

    // Counter wrap from a preloaded all-ones value.
    @(negedge clk);
    rst = 1'b0; opcode = OP_ALU; reg_write = 1'b1; mem_read = 1'b0; imem_ready = 1'b1;
    force dut.retired_q = 32'hFFFF_FFFF;
    @(negedge clk);
    #1;
    chk("wrap preload", retired, 32'hFFFF_FFFF);
    release dut.retired_q;
    repeat (2) @(negedge clk);
    #1;
    chk("wrap wb state", 32'(state), 32'd4);
    @(negedge clk);
    #1;
    chk("wrap retired", retired, 32'd0);

    // Illegal opcode: FAULT the cycle after DECODE, sticky until reset.
    opcode = 7'b0000000; reg_write = 1'b0;
    @(negedge clk);
    #1;
    chk("illegal decode", 32'(state), 32'd1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      #1;
      chk($sformatf("illegal sticky%0d state", c),   32'(state),     32'd6);
      chk($sformatf("illegal sticky%0d fault", c),   32'(fault),     32'd1);
      chk($sformatf("illegal sticky%0d strobes", c), 32'(strobes()), 32'd0);
    end
    rst = 1'b1;
    #1;
    chk("final rst fault", 32'(fault), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
